custom_gate_lut: RTL and testbench

- Parametrised, registered successor to the fixed 3-input custom gate.
- Evaluates N_OUT independent truth tables over an N_IN-bit input word.
- Tables are reloadable at run time through a shadow/commit configuration port.
- Input and output sit behind valid/ready handshakes, so the block drops straight into streaming datapaths in place of hard-coded gates.

---
 rtl/custom_gate_lut_pkg.sv | 15 +
 rtl/custom_gate_lut_if.sv | 34 +++
 rtl/custom_gate_lut_row.sv | 42 ++++
 rtl/custom_gate_lut.sv | 77 +++++++
 tb/tb_custom_gate_lut.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/custom_gate_lut_pkg.sv
// Shared constants and sizing helpers for the reloadable LUT gate.
package custom_gate_pkg;

  localparam logic [7:0] TABLE_XOR_AC  = 8'h5A;
  localparam logic [7:0] TABLE_PARITY3 = 8'h96;

  function automatic int table_width(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int sel_width(input int n_out);
    return (n_out > 1) ? $clog2(n_out) : 1;
  endfunction

endpackage

// File: rtl/custom_gate_lut_if.sv
// Data handshake plus shadow/commit configuration port of custom_gate_lut.
interface custom_gate_lut_if
  import custom_gate_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1
);

  localparam int TW = table_width(N_IN);
  localparam int SW = sel_width(N_OUT);

  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_data;
  logic             cfg_we;
  logic [SW-1:0]    cfg_sel;
  logic [TW-1:0]    cfg_table;
  logic             cfg_commit;
  logic             cfg_dirty;

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_table, cfg_commit,
    output in_ready, out_valid, out_data, cfg_dirty
  );

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_sel, cfg_table, cfg_commit,
    input  in_ready, out_valid, out_data, cfg_dirty
  );

endinterface

// File: rtl/custom_gate_lut_row.sv
// One active/shadow truth-table pair with its lookup mux.
module custom_gate_lut_row
  import custom_gate_pkg::*;
#(
  parameter int                            N_IN      = 3,
  parameter logic [table_width(N_IN)-1:0]  RESET_ROW = TABLE_XOR_AC
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_i,
  input  logic                           commit_i,
  input  logic [table_width(N_IN)-1:0]   table_i,
  input  logic [N_IN-1:0]                idx_i,
  output logic                           bit_o
);

  localparam int TW = table_width(N_IN);

  logic [TW-1:0] active_q, active_d;
  logic [TW-1:0] shadow_q, shadow_d;

  // Commit takes the shadow including a write landing in the same cycle.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_i)     shadow_d = table_i;
    if (commit_i) active_d = shadow_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= RESET_ROW;
      shadow_q <= RESET_ROW;
    end else begin
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

  assign bit_o = active_q[idx_i];

endmodule

// File: rtl/custom_gate_lut.sv
// N_OUT reloadable truth tables over an N_IN-bit word, one registered result stage.
module custom_gate_lut
  import custom_gate_pkg::*;
#(
  parameter int                                     N_IN        = 3,
  parameter int                                     N_OUT       = 1,
  parameter logic [N_OUT*table_width(N_IN)-1:0]     RESET_TABLE = {N_OUT{8'h5A}}
) (
  input  logic             clk,
  input  logic             rst_n,
  custom_gate_lut_if.slave bus
);

  localparam int TW = table_width(N_IN);

  logic [N_OUT-1:0] wr_vec;
  logic [N_OUT-1:0] lookup;
  logic             accept;
  logic             sel_ok;

  logic             out_valid_q, out_valid_d;
  logic [N_OUT-1:0] out_data_q, out_data_d;
  logic             dirty_q, dirty_d;

  assign sel_ok       = int'(bus.cfg_sel) < N_OUT;
  // Held low while in reset even though out_valid_q is already clear.
  assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar j = 0; j < N_OUT; j++) begin : g_row
    assign wr_vec[j] = bus.cfg_we && (int'(bus.cfg_sel) == j);

    custom_gate_lut_row #(
      .N_IN      (N_IN),
      .RESET_ROW (RESET_TABLE[j*TW +: TW])
    ) u_row (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_i     (wr_vec[j]),
      .commit_i (bus.cfg_commit),
      .table_i  (bus.cfg_table),
      .idx_i    (bus.in_data),
      .bit_o    (lookup[j])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    dirty_d     = dirty_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lookup;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (bus.cfg_commit)              dirty_d = 1'b0;
    else if (bus.cfg_we && sel_ok)   dirty_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      dirty_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      dirty_q     <= dirty_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.cfg_dirty = dirty_q;

endmodule

// File: tb/tb_custom_gate_lut.sv
// Scoreboard bench: drivers queue expected results, monitors pop on each output transfer.
module tb_custom_gate_lut;
  import custom_gate_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  custom_gate_lut_if #(.N_IN(3), .N_OUT(1)) b1();
  custom_gate_lut_if #(.N_IN(3), .N_OUT(3)) b2();

  custom_gate_lut #(.N_IN(3), .N_OUT(1), .RESET_TABLE(TABLE_XOR_AC)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  custom_gate_lut #(.N_IN(3), .N_OUT(3),
                    .RESET_TABLE({8'h00, TABLE_PARITY3, TABLE_XOR_AC})) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no handshake expected in_ready within bound", name);
  endtask

  always @(negedge clk) begin
    if (rst_n && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb1_unexpected: got %0h expected no output", b1.out_data);
      end else check("sb1_data", 16'(b1.out_data), q1.pop_front());
    end
    if (rst_n && b2.out_valid && b2.out_ready) begin
      if (q2.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb2_unexpected: got %0h expected no output", b2.out_data);
      end else check("sb2_data", 16'(b2.out_data), q2.pop_front());
    end
  end

  task automatic send1(input logic [2:0] d, input logic [15:0] exp);
    int n;
    b1.in_valid = 1'b1;
    b1.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!b1.in_ready && n < 20) begin n++; @(negedge clk); end
    if (!b1.in_ready) timeout_fail("send1_timeout");
    else q1.push_back(exp);
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [2:0] d, input logic [15:0] exp);
    int n;
    b2.in_valid = 1'b1;
    b2.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!b2.in_ready && n < 20) begin n++; @(negedge clk); end
    if (!b2.in_ready) timeout_fail("send2_timeout");
    else q2.push_back(exp);
    @(posedge clk); #1;
    b2.in_valid = 1'b0;
  endtask

  task automatic cfg1(input logic [7:0] tbl, input logic commit);
    b1.cfg_we = 1'b1; b1.cfg_sel = 1'b0; b1.cfg_table = tbl;
    @(posedge clk); #1;
    b1.cfg_we = 1'b0;
    if (commit) begin
      b1.cfg_commit = 1'b1;
      @(posedge clk); #1;
      b1.cfg_commit = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] STREAM_EXP = 8'b0101_1010;

  initial begin
    logic [7:0] exp_vec;
    int n;
    b1.in_valid = 0; b1.in_data = '0; b1.out_ready = 1;
    b1.cfg_we = 0; b1.cfg_sel = '0; b1.cfg_table = '0; b1.cfg_commit = 0;
    b2.in_valid = 0; b2.in_data = '0; b2.out_ready = 1;
    b2.cfg_we = 0; b2.cfg_sel = '0; b2.cfg_table = '0; b2.cfg_commit = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(b1.out_valid), 16'd0);
    check("rst_out_data",  16'(b1.out_data),  16'd0);
    check("rst_dirty",     16'(b1.cfg_dirty), 16'd0);
    check("rst_in_ready",  16'(b1.in_ready),  16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Default 5A table streamed back to back
    exp_vec = STREAM_EXP;
    for (int i = 0; i < 8; i++) send1(3'(i), 16'(exp_vec[i]));
    idle(2);

    // Backpressure: one result held while the next word waits
    b1.out_ready = 1'b0;
    send1(3'd3, 16'd1);
    b1.in_valid = 1'b1; b1.in_data = 3'd5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_valid", 16'(b1.out_valid), 16'd1);
      check("hold_data",  16'(b1.out_data),  16'd1);
      check("hold_ready", 16'(b1.in_ready),  16'd0);
    end
    @(posedge clk); #1;
    b1.out_ready = 1'b1;
    send1(3'd5, 16'd0);
    idle(2);

    // Shadow write is invisible until commit
    cfg1(TABLE_PARITY3, 1'b0);
    check("shadow_dirty", 16'(b1.cfg_dirty), 16'd1);
    send1(3'd7, 16'd0);
    b1.cfg_commit = 1'b1;
    @(posedge clk); #1;
    b1.cfg_commit = 1'b0;
    check("commit_dirty", 16'(b1.cfg_dirty), 16'd0);
    send1(3'd7, 16'd1);
    send1(3'd3, 16'd0);
    idle(2);

    // Commit on the same edge as an accept: that word still sees the old table
    cfg1(8'hFF, 1'b0);
    b1.cfg_commit = 1'b1;
    send1(3'd0, 16'd0);
    b1.cfg_commit = 1'b0;
    send1(3'd0, 16'd1);
    check("same_cycle_dirty", 16'(b1.cfg_dirty), 16'd0);
    idle(2);

    // Multi-output instance, out-of-range select ignored
    send2(3'd6, 16'h0001);
    b2.cfg_we = 1'b1; b2.cfg_sel = 2'd3; b2.cfg_table = 8'hFF;
    @(posedge clk); #1;
    b2.cfg_we = 1'b0;
    check("sel_oob_dirty", 16'(b2.cfg_dirty), 16'd0);
    send2(3'd6, 16'h0001);
    b2.cfg_we = 1'b1; b2.cfg_sel = 2'd2; b2.cfg_table = 8'h40;
    @(posedge clk); #1;
    b2.cfg_we = 1'b0;
    check("sel2_dirty", 16'(b2.cfg_dirty), 16'd1);
    b2.cfg_commit = 1'b1;
    @(posedge clk); #1;
    b2.cfg_commit = 1'b0;
    send2(3'd6, 16'h0005);
    idle(2);

    // Reset with a pending result and an uncommitted write
    cfg1(8'h00, 1'b0);
    b1.out_ready = 1'b0;
    b1.in_valid = 1'b1; b1.in_data = 3'd6;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    check("pre_rst_valid", 16'(b1.out_valid), 16'd1);
    check("pre_rst_dirty", 16'(b1.cfg_dirty), 16'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 16'(b1.out_valid), 16'd0);
    check("mid_rst_dirty", 16'(b1.cfg_dirty), 16'd0);
    check("mid_rst_ready", 16'(b1.in_ready),  16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b1;
    send1(3'd1, 16'd1);
    send1(3'd2, 16'd0);
    send1(3'd7, 16'd0);
    send1(3'd4, 16'd1);

    n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < 20) begin
      @(posedge clk); n++;
    end
    #1;
    if (q1.size() != 0 || q2.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: got %0d/%0d pending expected 0", q1.size(), q2.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
